// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter: merges master ports onto one slave port and routes
// each in-order response back to its issuing channel through an ID FIFO.
module sram_like_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int MAX_OUT  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            m_req,
    input  logic [NUM_CH-1:0]            m_wr,
    input  logic [2*NUM_CH-1:0]          m_size,
    input  logic [(DATA_W/8)*NUM_CH-1:0] m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]     m_addr,
    input  logic [DATA_W*NUM_CH-1:0]     m_wdata,
    output logic [NUM_CH-1:0]            m_addr_ok,
    output logic [NUM_CH-1:0]            m_data_ok,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         s_req,
    output logic                         s_wr,
    output logic [1:0]                   s_size,
    output logic [DATA_W/8-1:0]          s_wstrb,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic                         s_addr_ok,
    input  logic                         s_data_ok,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         err_unexp
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUT);

    logic              lock;
    logic [CH_W-1:0]   lock_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic              full;
    logic              hs;
    logic              pop;
    logic [CH_W-1:0]   id_mem [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [CH_W-1:0]   head_ch;

    // k-th candidate in search order: from 0 in fixed mode, from rr_ptr in round-robin.
    function automatic logic [CH_W-1:0] pick_idx(input logic [CH_W-1:0] start, input int k);
        int base;
        base = (ARB_MODE == 1) ? int'(start) : 0;
        return CH_W'((base + k) % NUM_CH);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (lock) begin
            grant_vld = m_req[lock_ch];
            grant_ch  = lock_ch;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!grant_vld && m_req[pick_idx(rr_ptr, k)]) begin
                    grant_vld = 1'b1;
                    grant_ch  = pick_idx(rr_ptr, k);
                end
            end
        end
    end

    assign full    = (count == FULL_CNT);
    assign s_req   = resetn & grant_vld & ~full;
    assign hs      = s_req & s_addr_ok;
    assign pop     = s_data_ok & (count != '0);
    assign head_ch = id_mem[rd_ptr];

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (hs)  m_addr_ok[grant_ch] = 1'b1;
        if (pop) m_data_ok[head_ch]  = 1'b1;
    end

    assign s_wr    = s_req & m_wr[grant_ch];
    assign s_size  = s_req ? m_size[grant_ch*2 +: 2]            : '0;
    assign s_wstrb = s_req ? m_wstrb[grant_ch*STRB_W +: STRB_W] : '0;
    assign s_addr  = s_req ? m_addr[grant_ch*ADDR_W +: ADDR_W]  : '0;
    assign s_wdata = s_req ? m_wdata[grant_ch*DATA_W +: DATA_W] : '0;

    assign m_rdata     = s_rdata;
    assign outstanding = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock      <= 1'b0;
            lock_ch   <= '0;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_unexp <= 1'b0;
        end else begin
            // Lock keeps the slave-side request stable until the slave accepts it.
            if (hs) begin
                lock <= 1'b0;
            end else if (s_req) begin
                lock    <= 1'b1;
                lock_ch <= grant_ch;
            end else if (lock && !m_req[lock_ch]) begin
                lock <= 1'b0;
            end

            if (hs)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (hs && ARB_MODE == 1)
                rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;

            if (s_data_ok && count == '0) err_unexp <= 1'b1;
        end
    end

    // NOTE: ID storage is deliberately not reset; an entry is only read while count covers it.
    always_ff @(posedge clk) begin
        if (hs) id_mem[wr_ptr] <= grant_ch;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench: a fixed-priority and a round-robin arbiter (3 channels, depth 4)
// checked every cycle against a queue-based transaction model.
module tb_sram_like_arbiter;

    localparam int NCH  = 3;
    localparam int MOUT = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;

    logic [NCH-1:0]      m_req     [2];
    logic [NCH-1:0]      m_wr      [2];
    logic [2*NCH-1:0]    m_size    [2];
    logic [4*NCH-1:0]    m_wstrb   [2];
    logic [AW*NCH-1:0]   m_addr    [2];
    logic [DW*NCH-1:0]   m_wdata   [2];
    logic [NCH-1:0]      m_addr_ok [2];
    logic [NCH-1:0]      m_data_ok [2];
    logic [DW-1:0]       m_rdata   [2];
    logic                s_req     [2];
    logic                s_wr      [2];
    logic [1:0]          s_size    [2];
    logic [3:0]          s_wstrb   [2];
    logic [AW-1:0]       s_addr    [2];
    logic [DW-1:0]       s_wdata   [2];
    logic                s_addr_ok [2];
    logic                s_data_ok [2];
    logic [DW-1:0]       s_rdata   [2];
    logic [2:0]          outstanding [2];
    logic                err_unexp [2];

    sram_like_arbiter #(.NUM_CH(NCH), .MAX_OUT(MOUT), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_fixed (
        .clk(clk), .resetn(resetn),
        .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]), .m_wstrb(m_wstrb[0]),
        .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_addr_ok(m_addr_ok[0]), .m_data_ok(m_data_ok[0]), .m_rdata(m_rdata[0]),
        .s_req(s_req[0]), .s_wr(s_wr[0]), .s_size(s_size[0]), .s_wstrb(s_wstrb[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
        .s_addr_ok(s_addr_ok[0]), .s_data_ok(s_data_ok[0]), .s_rdata(s_rdata[0]),
        .outstanding(outstanding[0]), .err_unexp(err_unexp[0])
    );

    sram_like_arbiter #(.NUM_CH(NCH), .MAX_OUT(MOUT), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_rr (
        .clk(clk), .resetn(resetn),
        .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]), .m_wstrb(m_wstrb[1]),
        .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_addr_ok(m_addr_ok[1]), .m_data_ok(m_data_ok[1]), .m_rdata(m_rdata[1]),
        .s_req(s_req[1]), .s_wr(s_wr[1]), .s_size(s_size[1]), .s_wstrb(s_wstrb[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
        .s_addr_ok(s_addr_ok[1]), .s_data_ok(s_data_ok[1]), .s_rdata(s_rdata[1]),
        .outstanding(outstanding[1]), .err_unexp(err_unexp[1])
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pending master requests, held grant, RR pointer, and the
    // ordered list of channels awaiting a response.
    bit pend     [2][NCH];
    bit mlock    [2];
    int mlock_ch [2];
    int mrr      [2];
    int mq       [2][MOUT];
    int mq_n     [2];
    bit merr     [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) pend[d][c] = 1'b0;
            mlock[d]    = 1'b0;
            mlock_ch[d] = 0;
            mrr[d]      = 0;
            mq_n[d]     = 0;
            merr[d]     = 1'b0;
            m_req[d]    = '0;
        end
    endtask

    function automatic bit idle();
        bit r;
        r = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (mq_n[d] != 0) r = 1'b0;
            for (int c = 0; c < NCH; c++) if (pend[d][c]) r = 1'b0;
        end
        return r;
    endfunction

    // Masters hold a request with stable fields until it is accepted.
    task automatic drive(input int p_req, input int p_aok, input int p_dok, input bit unexp);
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[d][c] && $urandom_range(99) < p_req) begin
                    pend[d][c]              = 1'b1;
                    m_wr[d][c]              = 1'($urandom_range(1));
                    m_size[d][c*2 +: 2]     = 2'($urandom_range(2));
                    m_wstrb[d][c*4 +: 4]    = 4'($urandom_range(15));
                    m_addr[d][c*AW +: AW]   = $urandom;
                    m_wdata[d][c*DW +: DW]  = $urandom;
                end
                m_req[d][c] = pend[d][c];
            end
            s_addr_ok[d] = ($urandom_range(99) < p_aok);
            s_data_ok[d] = unexp || (mq_n[d] > 0 && $urandom_range(99) < p_dok);
            s_rdata[d]   = $urandom;
        end
    endtask

    task automatic eval(input int d);
        int g;
        int c;
        bit gv, sreq, hs, pop;
        logic [NCH-1:0] eaok, edok;
        string p;
        p  = (d == 1) ? "rr" : "fix";
        g  = 0;
        gv = 1'b0;
        if (mlock[d]) begin
            gv = 1'b1;
            g  = mlock_ch[d];
        end else begin
            for (int k = 0; k < NCH; k++) begin
                c = (d == 1) ? (mrr[d] + k) % NCH : k;
                if (!gv && pend[d][c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
        sreq = gv && (mq_n[d] < MOUT);
        hs   = sreq && s_addr_ok[d];
        pop  = s_data_ok[d] && (mq_n[d] > 0);
        eaok = hs  ? (NCH'(1) << g)        : '0;
        edok = pop ? (NCH'(1) << mq[d][0]) : '0;

        check({p, ".s_req"},       64'(s_req[d]),       64'(sreq));
        check({p, ".m_addr_ok"},   64'(m_addr_ok[d]),   64'(eaok));
        check({p, ".m_data_ok"},   64'(m_data_ok[d]),   64'(edok));
        check({p, ".outstanding"}, 64'(outstanding[d]), 64'(mq_n[d]));
        check({p, ".err_unexp"},   64'(err_unexp[d]),   64'(merr[d]));
        check({p, ".m_rdata"},     64'(m_rdata[d]),     64'(s_rdata[d]));
        check({p, ".s_addr"},  64'(s_addr[d]),  sreq ? 64'(m_addr[d][g*AW +: AW])  : 64'd0);
        check({p, ".s_wdata"}, 64'(s_wdata[d]), sreq ? 64'(m_wdata[d][g*DW +: DW]) : 64'd0);
        check({p, ".s_wr"},    64'(s_wr[d]),    sreq ? 64'(m_wr[d][g])             : 64'd0);
        check({p, ".s_size"},  64'(s_size[d]),  sreq ? 64'(m_size[d][g*2 +: 2])    : 64'd0);
        check({p, ".s_wstrb"}, 64'(s_wstrb[d]), sreq ? 64'(m_wstrb[d][g*4 +: 4])   : 64'd0);

        if (s_data_ok[d] && mq_n[d] == 0) merr[d] = 1'b1;
        if (pop) begin
            for (int i = 0; i < MOUT - 1; i++) mq[d][i] = mq[d][i+1];
            mq_n[d]--;
        end
        if (hs) begin
            mq[d][mq_n[d]] = g;
            mq_n[d]++;
            pend[d][g] = 1'b0;
            mlock[d]   = 1'b0;
            mrr[d]     = (g + 1) % NCH;
        end else if (sreq) begin
            mlock[d]    = 1'b1;
            mlock_ch[d] = g;
        end
    endtask

    task automatic cycle(input int p_req, input int p_aok, input int p_dok, input bit unexp);
        @(negedge clk);
        drive(p_req, p_aok, p_dok, unexp);
        #2;
        eval(0);
        eval(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            m_req[d]     = '1;
            m_wr[d]      = '1;
            m_size[d]    = '0;
            m_wstrb[d]   = '1;
            m_addr[d]    = '1;
            m_wdata[d]   = '1;
            s_addr_ok[d] = 1'b1;
            s_data_ok[d] = 1'b1;
            s_rdata[d]   = '0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check("rst.s_req",       64'(s_req[d]),       64'd0);
            check("rst.m_addr_ok",   64'(m_addr_ok[d]),   64'd0);
            check("rst.m_data_ok",   64'(m_data_ok[d]),   64'd0);
            check("rst.outstanding", 64'(outstanding[d]), 64'd0);
            check("rst.err_unexp",   64'(err_unexp[d]),   64'd0);
        end
        @(negedge clk);
        model_reset();
        s_data_ok[0] = 1'b0;
        s_data_ok[1] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        repeat (600) cycle(50, 60, 20, 1'b0);
        repeat (600) cycle(40, 50, 60, 1'b0);
        repeat (100) cycle(100, 100, 100, 1'b0);
        repeat (300) cycle(30, 30, 50, 1'b0);

        n = 0;
        while (n < 60 && !idle()) begin
            cycle(0, 100, 100, 1'b0);
            n++;
        end
        check("drain_bound", 64'(idle()), 64'd1);

        cycle(0, 0, 0, 1'b1);
        cycle(0, 0, 0, 1'b0);

        n = 0;
        while (n < 20 && !(mq_n[0] >= 2 && mq_n[1] >= 2)) begin
            cycle(100, 100, 0, 1'b0);
            n++;
        end
        check("fill_bound", 64'(mq_n[0] >= 2 && mq_n[1] >= 2), 64'd1);

        // Reset asserted between clock edges with requests and a response pending.
        @(negedge clk);
        drive(100, 100, 100, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("arst.outstanding", 64'(outstanding[d]), 64'd0);
            check("arst.err_unexp",   64'(err_unexp[d]),   64'd0);
            check("arst.s_req",       64'(s_req[d]),       64'd0);
            check("arst.m_addr_ok",   64'(m_addr_ok[d]),   64'd0);
            check("arst.m_data_ok",   64'(m_data_ok[d]),   64'd0);
        end
        model_reset();
        s_data_ok[0] = 1'b0;
        s_data_ok[1] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (100) cycle(50, 60, 40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
